// File: rtl/par2ser_if.sv
// Parallel word handshake into the par2ser transmitter.
// master drives din/din_valid, slave returns din_ready.
interface par2ser_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;

    modport master (output din, din_valid, input din_ready);
    modport slave  (input din, din_valid, output din_ready);
endinterface

// File: rtl/par2ser.sv
// Parallel-to-serial transmitter: WIDTH-bit words in, one bit per clk out, gapless streaming.
// Optional even-parity trailer bit when PAR2SER_PARITY_EN is defined.
module par2ser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_LVL  = 1'b0
) (
    input  logic     clk,
    input  logic     rst_n,
    par2ser_if.slave s,
    output logic     dout,
    output logic     dout_valid,
    output logic     frame_start,
    output logic     busy
);
    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PAR2SER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    logic par;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             last_cycle;
    logic             xfer;

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

`ifdef PAR2SER_PARITY_EN
    assign last_cycle = (state == PARITY);
`else
    assign last_cycle = (state == SHIFT) && (cnt == LAST);
`endif

    // Ready on the last frame cycle lets the next word follow with no idle gap.
    assign s.din_ready = (state == IDLE) || last_cycle;
    assign xfer        = s.din_valid && s.din_ready;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            dout        <= IDLE_LVL;
            dout_valid  <= 1'b0;
            frame_start <= 1'b0;
`ifdef PAR2SER_PARITY_EN
            par         <= 1'b0;
`endif
        end else begin
            frame_start <= 1'b0;
            if (xfer) begin
                // First bit goes straight to dout; shreg keeps the remainder.
                state       <= SHIFT;
                cnt         <= '0;
                shreg       <= advance(s.din);
                dout        <= head_bit(s.din);
                dout_valid  <= 1'b1;
                frame_start <= 1'b1;
`ifdef PAR2SER_PARITY_EN
                par         <= ^s.din;
`endif
            end else begin
                case (state)
                    SHIFT: begin
                        if (cnt == LAST) begin
                            cnt <= '0;
`ifdef PAR2SER_PARITY_EN
                            state      <= PARITY;
                            dout       <= par;
                            dout_valid <= 1'b1;
`else
                            state      <= IDLE;
                            dout       <= IDLE_LVL;
                            dout_valid <= 1'b0;
`endif
                        end else begin
                            cnt        <= cnt + 1'b1;
                            dout       <= head_bit(shreg);
                            shreg      <= advance(shreg);
                            dout_valid <= 1'b1;
                        end
                    end
`ifdef PAR2SER_PARITY_EN
                    PARITY: begin
                        state      <= IDLE;
                        dout       <= IDLE_LVL;
                        dout_valid <= 1'b0;
                    end
`endif
                    default: begin
                        state      <= IDLE;
                        dout       <= IDLE_LVL;
                        dout_valid <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_par2ser.sv
// Bench for par2ser: MSB-first and LSB-first instances share stimulus and are
// checked against a queue-of-bits model of the serial stream.
module tb_par2ser;
    localparam int W = 8;
`ifdef PAR2SER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    par2ser_if #(.WIDTH(W)) im();
    par2ser_if #(.WIDTH(W)) il();

    logic dm, vm, fm, bm, dl, vl, fl, bl;

    par2ser #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LVL(1'b0)) u_msb (
        .clk(clk), .rst_n(rst_n), .s(im),
        .dout(dm), .dout_valid(vm), .frame_start(fm), .busy(bm)
    );
    par2ser #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LVL(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .s(il),
        .dout(dl), .dout_valid(vl), .frame_start(fl), .busy(bl)
    );

    typedef struct {bit m; bit l; bit st;} ebit_t;
    ebit_t q[$];
    ebit_t cur;
    bit    cur_v;
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected serial frame of a word, written out bit by bit in send order.
    task automatic push_word(input logic [W-1:0] w);
        ebit_t e;
        for (int i = 0; i < W; i++) begin
            e.m = w[W-1-i]; e.l = w[i]; e.st = (i == 0);
            q.push_back(e);
        end
        if (PAR) begin
            e.m = ^w; e.l = ^w; e.st = 1'b0;
            q.push_back(e);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/dout_m"},  dm, cur_v ? cur.m : 1'b0);
        chk({tag, "/dout_l"},  dl, cur_v ? cur.l : 1'b0);
        chk({tag, "/valid_m"}, vm, cur_v);
        chk({tag, "/valid_l"}, vl, cur_v);
        chk({tag, "/fstart_m"}, fm, cur_v && cur.st);
        chk({tag, "/fstart_l"}, fl, cur_v && cur.st);
        chk({tag, "/busy_m"},  bm, cur_v);
        chk({tag, "/busy_l"},  bl, cur_v);
        chk({tag, "/ready_m"}, im.din_ready, q.size() == 0);
        chk({tag, "/ready_l"}, il.din_ready, q.size() == 0);
    endtask

    // One clock: drive, check at negedge, model advances at posedge.
    task automatic cyc(input string tag, input bit v, input logic [W-1:0] d, output bit acc);
        im.din_valid = v; il.din_valid = v;
        im.din = d;       il.din = d;
        @(negedge clk);
        check_all(tag);
        acc = v && (q.size() == 0);
        @(posedge clk);
        if (acc) push_word(d);
        if (q.size() > 0) begin
            cur = q.pop_front(); cur_v = 1'b1;
        end else cur_v = 1'b0;
        #1;
    endtask

    task automatic idle(input string tag, input int n);
        bit acc;
        for (int i = 0; i < n; i++) cyc(tag, 1'b0, '0, acc);
    endtask

    task automatic send(input string tag, input logic [W-1:0] w);
        bit acc = 1'b0;
        int k = 0;
        while (!acc && k < 2 * W + 4) begin
            cyc(tag, 1'b1, w, acc);
            k++;
        end
        n_tests++;
        if (!acc) begin
            n_fail++;
            $error("FAIL %s/accept_timeout: got 0 expected 1", tag);
        end
    endtask

    // Async reset mid-cycle: outputs must drop with no clk edge.
    task automatic do_reset(input string tag, input bit v_at_release, input logic [W-1:0] d);
        rst_n = 1'b0;
        #1;
        q.delete(); cur_v = 1'b0;
        check_all({tag, "/async"});
        @(posedge clk); #1;
        check_all({tag, "/held"});
        im.din_valid = v_at_release; il.din_valid = v_at_release;
        im.din = d; il.din = d;
        rst_n = 1'b1;
    endtask

    initial begin
        bit acc;
        bit pending = 1'b0;
        logic [W-1:0] held = '0;
        im.din_valid = 1'b0; il.din_valid = 1'b0;
        im.din = '0; il.din = '0;
        cur_v = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("por");
        rst_n = 1'b1;
        idle("por_idle", 2);

        send("a5", 8'hA5);
        idle("a5_tail", W + 3);

        send("ff", 8'hFF);
        send("b2b_00", 8'h00);
        idle("b2b_tail", W + 3);

        send("lsb01", 8'h01);
        idle("lsb01_tail", W + 3);

        send("c3", 8'hC3);
        idle("c3_part", 2);
        do_reset("abort", 1'b0, '0);
        idle("abort_quiet", W + 2);
        send("81", 8'h81);
        idle("81_tail", W + 3);

        send("mid", 8'h3C);
        idle("mid_part", 4);
        do_reset("rel_valid", 1'b1, 8'h5A);
        cyc("rel_valid_acc", 1'b1, 8'h5A, acc);
        n_tests++;
        assert (acc && vm === 1'b1 && fm === 1'b1) else begin
            n_fail++;
            $error("FAIL rel_valid/first_edge: got valid=%0b fstart=%0b expected 1/1", vm, fm);
        end
        idle("rel_valid_tail", W + 3);

        if (PAR) begin
            send("par07", 8'h07);
            idle("par07_tail", W + 3);
            send("par03", 8'h03);
            idle("par03_tail", W + 3);
        end

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                pending = 1'b0;
                do_reset("rnd_rst", 1'b0, '0);
            end else if (pending) begin
                cyc("rnd", 1'b1, held, acc);
                if (acc) pending = 1'b0;
            end else begin
                bit v = ($urandom_range(0, 3) != 0);
                logic [W-1:0] d = W'($urandom);
                cyc("rnd", v, d, acc);
                if (v && !acc) begin
                    pending = 1'b1; held = d;
                end
            end
        end
        idle("final", W + 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
